sprite_motion_engine: RTL and testbench

//  Parametrised, frame-synchronous position engine for N rectangular sprites (paddles, ball, markers).

---
 rtl/vga_sprite_pkg.sv | 36 +++
 rtl/sprite_slot.sv | 72 +++++++
 rtl/sprite_motion_engine.sv | 243 ++++++++++++++++++++++++
 tb/tb_sprite_motion_engine.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sprite_pkg.sv
// Shared video constants, FSM state type and the coordinate clamp helper
// used by the sprite motion engine and its per-slot datapath.
package vga_sprite_pkg;

   localparam int VIDEO_WIDTH  = 640;
   localparam int VIDEO_HEIGHT = 480;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UPDATE = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Signed 32-bit math so cur+delta and hi-half never wrap at the coordinate width.
   function automatic int clamp_coord(input int cur, input int delta, input int lo,
                                      input int hi, input int half);
      int target;
      int minC;
      int maxC;
      int result;
      target = cur + delta;
      minC   = lo + half;
      maxC   = hi - half;
      if (maxC < minC) begin
         result = minC;
      end else if (target < minC) begin
         result = minC;
      end else if (target > maxC) begin
         result = maxC;
      end else begin
         result = target;
      end
      return result;
   endfunction

endpackage

// File: rtl/sprite_slot.sv
// One sprite's combinational datapath: strict-interior pixel hit test and the
// clamped next centre from either the direction inputs or a pending load.
module sprite_slot
   import vga_sprite_pkg::*;
#(
   parameter int X_W    = 10,
   parameter int Y_W    = 9,
   parameter int HALF_W = 25,
   parameter int HALF_H = 33,
   parameter int STEP   = 1
) (
   input  logic [X_W-1:0] posX,
   input  logic [Y_W-1:0] posY,
   input  logic [X_W-1:0] pixX,
   input  logic [Y_W-1:0] pixY,
   input  logic           mvUp,
   input  logic           mvDown,
   input  logic           mvLeft,
   input  logic           mvRight,
   input  logic           useLoad,
   input  logic [X_W-1:0] loadX,
   input  logic [Y_W-1:0] loadY,
   input  logic [X_W-1:0] winXlo,
   input  logic [X_W-1:0] winXhi,
   input  logic [Y_W-1:0] winYlo,
   input  logic [Y_W-1:0] winYhi,
   output logic           hit,
   output logic [X_W-1:0] nextX,
   output logic [Y_W-1:0] nextY
);

   int baseX;
   int baseY;
   int deltaX;
   int deltaY;

   // Select load target or stepped position, then clamp into the window.
   always_comb begin
      baseX  = int'(posX);
      baseY  = int'(posY);
      deltaX = 32'sd0;
      deltaY = 32'sd0;
      if (useLoad) begin
         baseX  = int'(loadX);
         baseY  = int'(loadY);
         deltaX = 32'sd0;
         deltaY = 32'sd0;
      end else begin
         if (mvRight && !mvLeft) begin
            deltaX = STEP;
         end else if (mvLeft && !mvRight) begin
            deltaX = -STEP;
         end else begin
            deltaX = 32'sd0;
         end
         if (mvDown && !mvUp) begin
            deltaY = STEP;
         end else if (mvUp && !mvDown) begin
            deltaY = -STEP;
         end else begin
            deltaY = 32'sd0;
         end
      end
      nextX = X_W'(clamp_coord(baseX, deltaX, int'(winXlo), int'(winXhi), HALF_W));
      nextY = Y_W'(clamp_coord(baseY, deltaY, int'(winYlo), int'(winYhi), HALF_H));
   end

   // Edges themselves are outside the sprite.
   assign hit = (int'(pixX) > int'(posX) - HALF_W) && (int'(pixX) < int'(posX) + HALF_W) &&
                (int'(pixY) > int'(posY) - HALF_H) && (int'(pixY) < int'(posY) + HALF_H);

endmodule

// File: rtl/sprite_motion_engine.sv
// Frame-synchronous position engine for N sprites with registered per-pixel hit,
// priority colour and load handshake. Optional overlap flags: SPRITE_COLLIDE_EN.
module sprite_motion_engine
   import vga_sprite_pkg::*;
#(
   parameter int N_SPRITES = 4,
   parameter int X_W       = 10,
   parameter int Y_W       = 9,
   parameter int HALF_W    = 25,
   parameter int HALF_H    = 33,
   parameter int STEP      = 1,
   parameter int COLOR_W   = 12,
   parameter logic [N_SPRITES*X_W-1:0]     INIT_X = {N_SPRITES{X_W'(VIDEO_WIDTH / 32'sd2)}},
   parameter logic [N_SPRITES*Y_W-1:0]     INIT_Y = {N_SPRITES{Y_W'(VIDEO_HEIGHT / 32'sd2)}},
   parameter logic [N_SPRITES*COLOR_W-1:0] COLORS = {N_SPRITES{COLOR_W'(32'd24)}},
   localparam int IDX_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       frame_end,
   input  logic [X_W-1:0]             pix_x,
   input  logic [Y_W-1:0]             pix_y,
   input  logic [N_SPRITES-1:0]       mv_up,
   input  logic [N_SPRITES-1:0]       mv_down,
   input  logic [N_SPRITES-1:0]       mv_left,
   input  logic [N_SPRITES-1:0]       mv_right,
   input  logic [N_SPRITES*X_W-1:0]   win_xlo,
   input  logic [N_SPRITES*X_W-1:0]   win_xhi,
   input  logic [N_SPRITES*Y_W-1:0]   win_ylo,
   input  logic [N_SPRITES*Y_W-1:0]   win_yhi,
   input  logic                       load_valid,
   output logic                       load_ready,
   input  logic [IDX_W-1:0]           load_idx,
   input  logic [X_W-1:0]             load_x,
   input  logic [Y_W-1:0]             load_y,
   output logic [N_SPRITES*X_W-1:0]   pos_x,
   output logic [N_SPRITES*Y_W-1:0]   pos_y,
   output logic                       update_done,
   output logic                       hit,
   output logic [IDX_W-1:0]           hit_idx,
   output logic [COLOR_W-1:0]         hit_color,
   output logic [N_SPRITES-1:0]       collide
);

   state_t           state;
   state_t           stateNext;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idxNext;
   logic             feQ;
   logic             start;
   logic             accept;
   logic             loadFire;
   logic             pendApplied;
   logic             pendValid;
   logic             pendValidNext;
   logic [IDX_W-1:0] pendIdx;
   logic [X_W-1:0]   pendX;
   logic [Y_W-1:0]   pendY;

   logic [N_SPRITES-1:0] slotHit;
   logic [X_W-1:0]       slotNextX [N_SPRITES];
   logic [Y_W-1:0]       slotNextY [N_SPRITES];
   logic                 anyHit;
   logic [IDX_W-1:0]     winIdx;
   logic [COLOR_W-1:0]   winColor;

   assign start       = frame_end && !feQ;
   assign accept      = start && (state == IDLE);
   assign loadFire    = load_valid && load_ready;
   assign pendApplied = (state == UPDATE) && pendValid && (pendIdx == idx);

   for (genvar g = 0; g < N_SPRITES; g++) begin : gSlot
      sprite_slot #(
         .X_W    (X_W),
         .Y_W    (Y_W),
         .HALF_W (HALF_W),
         .HALF_H (HALF_H),
         .STEP   (STEP)
      ) uSlot (
         .posX    (pos_x[g*X_W +: X_W]),
         .posY    (pos_y[g*Y_W +: Y_W]),
         .pixX    (pix_x),
         .pixY    (pix_y),
         .mvUp    (mv_up[g]),
         .mvDown  (mv_down[g]),
         .mvLeft  (mv_left[g]),
         .mvRight (mv_right[g]),
         .useLoad (pendValid && (pendIdx == IDX_W'(g))),
         .loadX   (pendX),
         .loadY   (pendY),
         .winXlo  (win_xlo[g*X_W +: X_W]),
         .winXhi  (win_xhi[g*X_W +: X_W]),
         .winYlo  (win_ylo[g*Y_W +: Y_W]),
         .winYhi  (win_yhi[g*Y_W +: Y_W]),
         .hit     (slotHit[g]),
         .nextX   (slotNextX[g]),
         .nextY   (slotNextY[g])
      );
   end

   // Sweep sequencing: one slot per UPDATE cycle, then a single DONE cycle.
   always_comb begin
      stateNext = state;
      idxNext   = idx;
      case (state)
         IDLE: begin
            if (accept) begin
               stateNext = UPDATE;
               idxNext   = {IDX_W{1'b0}};
            end else begin
               stateNext = IDLE;
               idxNext   = idx;
            end
         end
         UPDATE: begin
            if (idx == IDX_W'(N_SPRITES - 1)) begin
               stateNext = DONE;
               idxNext   = idx;
            end else begin
               stateNext = UPDATE;
               idxNext   = idx + IDX_W'(1);
            end
         end
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Out-of-range targets complete the handshake but never become pending.
   always_comb begin
      if (loadFire) begin
         pendValidNext = (int'(load_idx) < N_SPRITES);
      end else if (pendApplied) begin
         pendValidNext = 1'b0;
      end else begin
         pendValidNext = pendValid;
      end
   end

   // Control registers; ready and done are derived from next-state so they are registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         feQ         <= 1'b0;
         state       <= IDLE;
         idx         <= {IDX_W{1'b0}};
         pendValid   <= 1'b0;
         load_ready  <= 1'b1;
         update_done <= 1'b0;
      end else begin
         feQ         <= frame_end;
         state       <= stateNext;
         idx         <= idxNext;
         pendValid   <= pendValidNext;
         load_ready  <= (stateNext == IDLE) && !pendValidNext;
         update_done <= (stateNext == DONE);
      end
   end

   // Captured load request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pendIdx <= {IDX_W{1'b0}};
         pendX   <= {X_W{1'b0}};
         pendY   <= {Y_W{1'b0}};
      end else if (loadFire) begin
         pendIdx <= load_idx;
         pendX   <= load_x;
         pendY   <= load_y;
      end else begin
         pendIdx <= pendIdx;
         pendX   <= pendX;
         pendY   <= pendY;
      end
   end

   // Only the slot addressed by idx is written during its UPDATE cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pos_x <= INIT_X;
         pos_y <= INIT_Y;
      end else begin
         for (int i = 0; i < N_SPRITES; i++) begin
            if ((state == UPDATE) && (idx == IDX_W'(i))) begin
               pos_x[i*X_W +: X_W] <= slotNextX[i];
               pos_y[i*Y_W +: Y_W] <= slotNextY[i];
            end
         end
      end
   end

   // Priority encoder: scanning downward leaves the lowest hitting index.
   always_comb begin
      anyHit   = 1'b0;
      winIdx   = {IDX_W{1'b0}};
      winColor = {COLOR_W{1'b0}};
      for (int i = N_SPRITES - 1; i >= 0; i--) begin
         if (slotHit[i]) begin
            anyHit   = 1'b1;
            winIdx   = IDX_W'(i);
            winColor = COLORS[i*COLOR_W +: COLOR_W];
         end else begin
            anyHit   = anyHit;
         end
      end
   end

   // Registered pixel result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit       <= 1'b0;
         hit_idx   <= {IDX_W{1'b0}};
         hit_color <= {COLOR_W{1'b0}};
      end else begin
         hit       <= anyHit;
         hit_idx   <= winIdx;
         hit_color <= winColor;
      end
   end

`ifdef SPRITE_COLLIDE_EN
   logic [N_SPRITES-1:0] overlapAcc;

   // Accumulate slots seen overlapping during the frame; publish on frame start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overlapAcc <= {N_SPRITES{1'b0}};
         collide    <= {N_SPRITES{1'b0}};
      end else if (accept) begin
         overlapAcc <= {N_SPRITES{1'b0}};
         collide    <= overlapAcc;
      end else if ((slotHit & (slotHit - N_SPRITES'(1))) != {N_SPRITES{1'b0}}) begin
         overlapAcc <= overlapAcc | slotHit;
         collide    <= collide;
      end else begin
         overlapAcc <= overlapAcc;
         collide    <= collide;
      end
   end
`else
   assign collide = {N_SPRITES{1'b0}};
`endif

endmodule

// File: tb/tb_sprite_motion_engine.sv
// Directed scoreboard bench for sprite_motion_engine (4 slots, 640x480 windows).
module tb_sprite_motion_engine;

   localparam int N  = 4;
   localparam int XW = 10;
   localparam int YW = 9;
   localparam logic [47:0] COLS = {12'h0F0, 12'h00F, 12'hF00, 12'hABC};
`ifdef SPRITE_COLLIDE_EN
   localparam logic [31:0] EXP_OVERLAP = 32'h3;
`else
   localparam logic [31:0] EXP_OVERLAP = 32'h0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          frame_end;
   logic [XW-1:0] pix_x;
   logic [YW-1:0] pix_y;
   logic [N-1:0]  mv_up, mv_down, mv_left, mv_right;
   logic [N*XW-1:0] win_xlo, win_xhi;
   logic [N*YW-1:0] win_ylo, win_yhi;
   logic          load_valid;
   logic          load_ready;
   logic [1:0]    load_idx;
   logic [XW-1:0] load_x;
   logic [YW-1:0] load_y;
   logic [N*XW-1:0] pos_x;
   logic [N*YW-1:0] pos_y;
   logic          update_done;
   logic          hit;
   logic [1:0]    hit_idx;
   logic [11:0]   hit_color;
   logic [N-1:0]  collide;

   sprite_motion_engine #(
      .N_SPRITES(N), .X_W(XW), .Y_W(YW), .HALF_W(25), .HALF_H(33), .STEP(1), .COLOR_W(12),
      .INIT_X({4{10'd320}}), .INIT_Y({4{9'd240}}), .COLORS(COLS)
   ) dut (
      .clk(clk), .reset(reset), .frame_end(frame_end), .pix_x(pix_x), .pix_y(pix_y),
      .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left), .mv_right(mv_right),
      .win_xlo(win_xlo), .win_xhi(win_xhi), .win_ylo(win_ylo), .win_yhi(win_yhi),
      .load_valid(load_valid), .load_ready(load_ready), .load_idx(load_idx),
      .load_x(load_x), .load_y(load_y), .pos_x(pos_x), .pos_y(pos_y),
      .update_done(update_done), .hit(hit), .hit_idx(hit_idx), .hit_color(hit_color),
      .collide(collide)
   );

   always #5 clk = ~clk;

   int nCompared   = 0;
   int nMismatched = 0;
   logic [31:0] expQ[$];
   string       tagQ[$];

   task automatic push(input string tag, input logic [31:0] value);
      tagQ.push_back(tag);
      expQ.push_back(value);
   endtask

   task automatic check(input logic [31:0] observed);
      string       tag;
      logic [31:0] expected;
      nCompared++;
      if (expQ.size() == 0) begin
         nMismatched++;
         $error("FAIL scoreboard_empty: observed %0d, expected <none>", observed);
      end else begin
         tag      = tagQ.pop_front();
         expected = expQ.pop_front();
         assert (observed === expected) else begin
            nMismatched++;
            $error("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
         end
      end
   endtask

   function automatic logic [31:0] getX(input int i);
      return 32'(pos_x[i*XW +: XW]);
   endfunction

   function automatic logic [31:0] getY(input int i);
      return 32'(pos_y[i*YW +: YW]);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setWinAll();
      win_xlo = '0;
      win_xhi = {4{10'd639}};
      win_ylo = '0;
      win_yhi = {4{9'd479}};
   endtask

   task automatic runFrame(output int lat);
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
      lat = 0;
      while (!update_done && lat < 40) begin
         tick();
         lat++;
      end
      if (!update_done) begin
         nCompared++;
         nMismatched++;
         $error("FAIL frame_timeout: observed no update_done in %0d cycles, expected a pulse", lat);
      end
      tick();
   endtask

   task automatic loadSlot(input int i, input int x, input int y);
      int w = 0;
      int lat;
      while (!load_ready && w < 40) begin
         tick();
         w++;
      end
      load_idx   = 2'(i);
      load_x     = 10'(x);
      load_y     = 9'(y);
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      runFrame(lat);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int cnt;
      int px [7] = '{105, 130, 125, 135, 105, 105, 300};
      int py [7] = '{100, 100, 100, 100, 133, 132, 100};
      int eh [7] = '{1, 1, 1, 0, 0, 1, 1};
      int ei [7] = '{0, 1, 1, 0, 0, 0, 2};
      int ec [7] = '{12'hABC, 12'hF00, 12'hF00, 0, 0, 12'hABC, 12'h00F};

      reset = 1'b1; frame_end = 1'b0; pix_x = '0; pix_y = '0;
      mv_up = '0; mv_down = '0; mv_left = '0; mv_right = '0;
      load_valid = 1'b0; load_idx = '0; load_x = '0; load_y = '0;
      setWinAll();

      // Reset state
      push("rst_ready", 32'd1); push("rst_hit", 32'd0); push("rst_done", 32'd0);
      push("rst_collide", 32'd0); push("rst_x0", 32'd320); push("rst_y3", 32'd240);
      tick(); tick();
      check(32'(load_ready)); check(32'(hit)); check(32'(update_done));
      check(32'(collide)); check(getX(0)); check(getY(3));
      reset = 1'b0;
      tick();

      // Reset in the middle of a sweep (idx = 2)
      mv_right = 4'hF;
      frame_end = 1'b1; tick(); frame_end = 1'b0;
      tick(); tick();
      push("pre_rst_x0", 32'd321); check(getX(0));
      #2 reset = 1'b1;
      #1;
      push("mid_rst_x0", 32'd320); push("mid_rst_x1", 32'd320); push("mid_rst_ready", 32'd1);
      check(getX(0)); check(getX(1)); check(32'(load_ready));
      mv_right = '0;
      #1 reset = 1'b0;
      tick();
      push("post_rst_hit", 32'd0); push("post_rst_ready", 32'd1);
      check(32'(hit)); check(32'(load_ready));
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (update_done) cnt++;
      end
      push("post_rst_idle", 32'd0); check(32'(cnt));

      // Slot 0 pushed left into its window edge
      loadSlot(0, 80, 240);
      push("load_x0", 32'd80); check(getX(0));
      mv_left = 4'b0001;
      for (int f = 1; f <= 60; f++) begin
         runFrame(lat);
         if (f == 1) begin
            push("left_f1", 32'd79); check(getX(0));
         end else if (f == 54) begin
            push("left_f54", 32'd26); check(getX(0));
         end else if (f == 55) begin
            push("left_f55", 32'd25); check(getX(0));
         end else if (f == 60) begin
            push("left_f60", 32'd25); check(getX(0));
         end
      end
      mv_left = '0;

      // Opposing vertical requests cancel; a start mid-sweep is ignored
      mv_up = 4'b0010; mv_down = 4'b0010; mv_right = 4'b0010;
      frame_end = 1'b1; tick(); frame_end = 1'b0; tick();
      frame_end = 1'b1; tick(); frame_end = 1'b0;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (update_done) cnt++;
      end
      push("one_sweep", 32'd1); push("opp_x1_a", 32'd321); push("opp_y1_a", 32'd240);
      check(32'(cnt)); check(getX(1)); check(getY(1));
      runFrame(lat);
      push("opp_x1_b", 32'd322); push("opp_y1_b", 32'd240);
      check(getX(1)); check(getY(1));
      mv_up = '0; mv_down = '0; mv_right = '0;

      // Load handshake into slot 2
      push("ld_ready_idle", 32'd1); check(32'(load_ready));
      load_idx = 2'd2; load_x = 10'd300; load_y = 9'd100; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      push("ld_ready_drop", 32'd0); push("ld_x2_before", 32'd320);
      check(32'(load_ready)); check(getX(2));
      frame_end = 1'b1; tick(); frame_end = 1'b0;
      lat = 0;
      while (!update_done && lat < 40) begin
         tick();
         lat++;
      end
      push("ld_latency", 32'd4); push("ld_x2", 32'd300); push("ld_y2", 32'd100);
      push("ld_ready_done", 32'd0);
      check(32'(lat)); check(getX(2)); check(getY(2)); check(32'(load_ready));
      tick();
      push("ld_ready_back", 32'd1); check(32'(load_ready));

      // Loaded coordinates are clamped to the window
      loadSlot(2, 700, 470);
      push("clamp_x2_hi", 32'd614); push("clamp_y2_hi", 32'd446);
      check(getX(2)); check(getY(2));
      loadSlot(2, 300, 100);

      // Window narrower than the sprite pins slot 3 to lo+HALF
      win_xlo[30 +: 10] = 10'd100;
      win_xhi[30 +: 10] = 10'd140;
      runFrame(lat);
      push("narrow_x3", 32'd125); push("narrow_y3", 32'd240);
      check(getX(3)); check(getY(3));
      setWinAll();
      runFrame(lat);
      push("narrow_hold_x3", 32'd125); check(getX(3));

      // Pixel hit test, priority and strict edges
      loadSlot(0, 100, 100);
      loadSlot(1, 110, 100);
      for (int k = 0; k < 7; k++) begin
         pix_x = 10'(px[k]);
         pix_y = 9'(py[k]);
         push($sformatf("hit_%0d_%0d", px[k], py[k]), 32'(eh[k]));
         push($sformatf("idx_%0d_%0d", px[k], py[k]), 32'(ei[k]));
         push($sformatf("col_%0d_%0d", px[k], py[k]), 32'(ec[k]));
         tick();
         check(32'(hit)); check(32'(hit_idx)); check(32'(hit_color));
      end

      // Overlap flags over one frame, then after separation
      pix_x = 10'd105; pix_y = 9'd100;
      tick(); tick(); tick();
      pix_x = '0; pix_y = '0;
      tick();
      loadSlot(1, 400, 300);
      push("collide_overlap", EXP_OVERLAP); check(32'(collide));
      pix_x = 10'd105; pix_y = 9'd100;
      tick(); tick(); tick();
      push("sep_hit_idx", 32'd0); check(32'(hit_idx));
      pix_x = '0; pix_y = '0;
      tick();
      runFrame(lat);
      push("collide_clear", 32'd0); check(32'(collide));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
